// File: rtl/jif_pkg.sv
// Shared definitions for the fetch/decode/writeback sequencer: opcodes,
// FSM state encoding and instruction word field positions.
package jif_pkg;

  // ALU opcodes (7-bit op field)
  localparam logic [6:0] OP_ADD  = 7'd0;
  localparam logic [6:0] OP_SUB  = 7'd1;
  localparam logic [6:0] OP_SHL  = 7'd2;
  localparam logic [6:0] OP_SHR  = 7'd3;
  localparam logic [6:0] OP_MOV  = 7'd4;
  localparam logic [6:0] OP_LDH  = 7'd5;
  localparam logic [6:0] OP_LDH2 = 7'd6;
  localparam logic [6:0] OP_MOV2 = 7'd7;
  localparam logic [6:0] OP_EQ   = 7'd8;
  localparam logic [6:0] OP_LT   = 7'd9;
  localparam logic [6:0] OP_GT   = 7'd10;
  localparam logic [6:0] OP_NF   = 7'd11;
  localparam logic [6:0] OP_AND  = 7'd12;
  localparam logic [6:0] OP_NF2  = 7'd13;
  localparam logic [6:0] OP_BR   = 7'd14;
  localparam logic [6:0] OP_HALT = 7'd127;

  // Instruction word field positions
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 25;
  localparam int RD_MSB = 24;
  localparam int RD_LSB = 21;
  localparam int RA_MSB = 20;
  localparam int RA_LSB = 17;
  localparam int HL_BIT = 16;
  localparam int VAL_MSB = 15;
  localparam int VAL_LSB = 0;
  localparam int RB_MSB = 15;
  localparam int RB_LSB = 12;

  // Sequencer states
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  // Ops that consume the second register operand (rb overlaps the immediate)
  function automatic logic uses_rb(input logic [6:0] op);
    return (op <= OP_SHR) || ((op >= OP_EQ) && (op <= OP_GT));
  endfunction

  // Ops whose result is written back to R[rd]
  function automatic logic writes_reg(input logic [6:0] op);
    return (op <= OP_MOV2);
  endfunction

  // Ops that update the flag pair
  function automatic logic writes_flags(input logic [6:0] op);
    return (op >= OP_EQ) && (op <= OP_NF2);
  endfunction

  // Unused opcode range
  function automatic logic is_illegal(input logic [6:0] op);
    return (op > OP_BR) && (op < OP_HALT);
  endfunction

endpackage

// File: rtl/jif_regfile.sv
// 16x32 register file: two combinational read ports, one synchronous
// write port, asynchronous clear, and a dedicated R8 tap for the ALU.
module jif_regfile
  import jif_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  ra_sel,
  input  logic [3:0]  rb_sel,
  output logic [31:0] ra_data,
  output logic [31:0] rb_data,
  input  logic        we,
  input  logic [3:0]  wsel,
  input  logic [31:0] wdata,
  output logic [31:0] r8
);

  logic [31:0] regs [NREG];

  // Storage: cleared on reset, single write port
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wsel] <= wdata;
    end
  end

  // Read ports see the stored value; no write-through bypass is needed
  // because operand reads and writeback never share a cycle.
  always_comb begin
    ra_data = regs[ra_sel];
    rb_data = regs[rb_sel];
    r8      = regs[8];
  end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode/writeback sequencer in front of the ALU. Handshakes:
// mem_req is held high with a stable mem_addr until mem_ack is sampled
// high at a rising edge; mem_rdata is taken on that same edge. alu_exec is
// a one-cycle strobe, high only in EXEC, during which all alu_* inputs
// are stable; ALU results are taken on the edge that closes EXEC.
module fetch_decode
  import jif_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          NREG     = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        alu_exec,
  output logic [6:0]  alu_instr,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] alu_reg8,
  output logic [15:0] alu_value,
  output logic        alu_highlow,
  output logic        alu_f1,
  output logic        alu_f2,
  input  logic [31:0] alu_c,
  input  logic        alu_f3,
  input  logic        alu_addrch,
  input  logic [31:0] alu_naddr,
  output logic        halted,
  output logic        illegal,
  output logic [2:0]  dbg_state
);

  state_t      state, state_nx;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        req_q;
  logic [6:0]  instr_q;
  logic [31:0] a_q, b_q;
  logic [15:0] value_q;
  logic        hl_q;
  logic        f1_q, f2_q;
  logic [31:0] c_q;
  logic        f3_q;
  logic        addrch_q;
  logic [31:0] naddr_q;

  logic [6:0]  ir_op;
  logic [3:0]  ir_rd, ir_ra, ir_rb;
  logic [31:0] ra_data, rb_data, r8_data;
  logic        rf_we;
  logic        ack_taken;

  assign ir_op = ir[OP_MSB:OP_LSB];
  assign ir_rd = ir[RD_MSB:RD_LSB];
  assign ir_ra = ir[RA_MSB:RA_LSB];
  assign ir_rb = ir[RB_MSB:RB_LSB];

  assign ack_taken = (state == S_FETCH) && req_q && mem_ack;

  jif_regfile #(.NREG(NREG)) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .ra_sel  (ir_ra),
    .rb_sel  (ir_rb),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .we      (rf_we),
    .wsel    (ir_rd),
    .wdata   (c_q),
    .r8      (r8_data)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  // Next-state and per-state strobes
  always_comb begin
    state_nx = state;
    alu_exec = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;
    rf_we    = 1'b0;
    case (state)
      S_FETCH:  if (ack_taken) state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        alu_exec = 1'b1;
        state_nx = S_WB;
      end
      S_WB: begin
        illegal  = is_illegal(ir_op);
        rf_we    = writes_reg(ir_op);
        state_nx = (ir_op == OP_HALT) ? S_HALT : S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_nx = S_FETCH;
    endcase
  end

  // Fetch request, PC, instruction latch, operand capture, result capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      ir       <= '0;
      req_q    <= 1'b0;
      instr_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      value_q  <= '0;
      hl_q     <= 1'b0;
      f1_q     <= 1'b0;
      f2_q     <= 1'b0;
      c_q      <= '0;
      f3_q     <= 1'b0;
      addrch_q <= 1'b0;
      naddr_q  <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (ack_taken) begin
            ir    <= mem_rdata;
            req_q <= 1'b0;
          end else begin
            req_q <= 1'b1;
          end
        end
        S_DECODE: begin
          instr_q <= ir_op;
          a_q     <= ra_data;
          b_q     <= uses_rb(ir_op) ? rb_data : 32'h0;
          value_q <= ir[VAL_MSB:VAL_LSB];
          hl_q    <= ir[HL_BIT];
        end
        S_EXEC: begin
          c_q      <= alu_c;
          f3_q     <= alu_f3;
          addrch_q <= alu_addrch;
          naddr_q  <= alu_naddr;
        end
        S_WB: begin
          if (writes_flags(ir_op)) begin
            f2_q <= f1_q;
            f1_q <= f3_q;
          end
          if (ir_op == OP_BR) begin
            pc <= addrch_q ? naddr_q : pc + 32'd1;
          end else if (ir_op != OP_HALT) begin
            pc <= pc + 32'd1;
          end
          // Request the next word right away so FETCH can finish in one cycle
          req_q <= (ir_op != OP_HALT);
        end
        default: req_q <= 1'b0;
      endcase
    end
  end

  assign mem_req     = req_q;
  assign mem_addr    = pc;
  assign alu_instr   = instr_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_reg8    = r8_data;
  assign alu_value   = value_q;
  assign alu_highlow = hl_q;
  assign alu_f1      = f1_q;
  assign alu_f2      = f2_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: the bench plays memory and ALU; a
// scoreboard queues the expected fetch address, ALU operand packet and
// illegal flag per instruction, and a monitor pops and compares them.
module tb_fetch_decode;
  import jif_pkg::*;

  logic        clock;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        alu_exec;
  logic [6:0]  alu_instr;
  logic [31:0] alu_a, alu_b, alu_reg8;
  logic [15:0] alu_value;
  logic        alu_highlow, alu_f1, alu_f2;
  logic [31:0] alu_c;
  logic        alu_f3, alu_addrch;
  logic [31:0] alu_naddr;
  logic        halted, illegal;
  logic [2:0]  dbg_state;

  fetch_decode #(.RESET_PC(32'h0), .NREG(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .alu_exec    (alu_exec),
    .alu_instr   (alu_instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_reg8    (alu_reg8),
    .alu_value   (alu_value),
    .alu_highlow (alu_highlow),
    .alu_f1      (alu_f1),
    .alu_f2      (alu_f2),
    .alu_c       (alu_c),
    .alu_f3      (alu_f3),
    .alu_addrch  (alu_addrch),
    .alu_naddr   (alu_naddr),
    .halted      (halted),
    .illegal     (illegal),
    .dbg_state   (dbg_state)
  );

  typedef struct {
    logic [6:0]  instr;
    logic [31:0] a;
    logic [31:0] b;
    logic        chk_b;
    logic [15:0] value;
    logic        hl;
    logic [31:0] r8;
    logic        f1;
    logic        f2;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [0:0]  exp_ill_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [3:0] rd,
                                     input logic [3:0] ra, input logic hl,
                                     input logic [15:0] val);
    return {op, rd, ra, hl, val};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    #2;
    if (!reset) begin
      if (mem_req && mem_ack) begin
        if (exp_addr_q.size() == 0) chk("fetch_unexpected", 32'd1, 32'd0);
        else chk("fetch_addr", mem_addr, exp_addr_q.pop_front());
      end
      if (alu_exec) begin
        if (exp_q.size() == 0) begin
          chk("exec_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("alu_instr", {25'd0, alu_instr}, {25'd0, e.instr});
          chk("alu_a", alu_a, e.a);
          if (e.chk_b) chk("alu_b", alu_b, e.b);
          chk("alu_value", {16'd0, alu_value}, {16'd0, e.value});
          chk("alu_highlow", {31'd0, alu_highlow}, {31'd0, e.hl});
          chk("alu_reg8", alu_reg8, e.r8);
          chk("alu_f1", {31'd0, alu_f1}, {31'd0, e.f1});
          chk("alu_f2", {31'd0, alu_f2}, {31'd0, e.f2});
        end
      end
      if (dbg_state == S_WB) begin
        if (exp_ill_q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
        else chk("illegal_in_wb", {31'd0, illegal}, {31'd0, exp_ill_q.pop_front()});
      end else if (illegal) begin
        chk("illegal_outside_wb", {31'd0, illegal}, 32'd0);
      end
      if (alu_exec && dbg_state != S_EXEC)
        chk("exec_outside_exec", {29'd0, dbg_state}, {29'd0, S_EXEC});
    end
  end

  // ---------------- driver ----------------
  // Serves one fetch (with ack withheld for 'delay' cycles), then plays the
  // ALU for that instruction. With 'abort' set, reset is pulsed mid-EXEC.
  task automatic run_instr(input logic [31:0] word, input logic [31:0] exp_addr,
                           input int delay,
                           input logic [31:0] exp_a, input logic [31:0] exp_b,
                           input logic chk_b, input logic [31:0] exp_r8,
                           input logic exp_f1, input logic exp_f2,
                           input logic [31:0] c, input logic f3,
                           input logic addrch, input logic [31:0] naddr,
                           input logic exp_ill, input logic abort);
    exp_t e;
    bit   got;
    e.instr = word[31:25];
    e.a     = exp_a;
    e.b     = exp_b;
    e.chk_b = chk_b;
    e.value = word[15:0];
    e.hl    = word[16];
    e.r8    = exp_r8;
    e.f1    = exp_f1;
    e.f2    = exp_f2;
    exp_addr_q.push_back(exp_addr);
    exp_q.push_back(e);
    if (!abort) exp_ill_q.push_back(exp_ill);

    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (mem_req) begin got = 1'b1; break; end
    end
    if (!got) begin
      chk("req_timeout", 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < delay; i++) begin
      chk("req_held", {31'd0, mem_req}, 32'd1);
      chk("addr_held", mem_addr, exp_addr);
      @(negedge clock);
    end
    mem_ack   = 1'b1;
    mem_rdata = word;
    @(posedge clock);
    #1 mem_ack = 1'b0;

    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (alu_exec) begin got = 1'b1; break; end
    end
    if (!got) begin
      chk("exec_timeout", 32'd0, 32'd1);
      return;
    end
    alu_c      = c;
    alu_f3     = f3;
    alu_addrch = addrch;
    alu_naddr  = naddr;
    if (abort) begin
      #3 reset = 1'b1;
      #1;
      chk("rst_exec_drop", {31'd0, alu_exec}, 32'd0);
      chk("rst_req_drop", {31'd0, mem_req}, 32'd0);
      mem_ack = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      chk("ack_in_reset_ignored", {29'd0, dbg_state}, {29'd0, S_FETCH});
      chk("req_after_reset", {31'd0, mem_req}, 32'd1);
      chk("addr_after_reset", mem_addr, 32'h0);
      mem_ack = 1'b0;
    end else begin
      @(posedge clock);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset      = 1'b1;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    alu_c      = '0;
    alu_f3     = 1'b0;
    alu_addrch = 1'b0;
    alu_naddr  = '0;
    repeat (3) @(negedge clock);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_alu_exec", {31'd0, alu_exec}, 32'd0);
    chk("rst_alu_instr", {25'd0, alu_instr}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_reg8", alu_reg8, 32'd0);
    chk("rst_alu_value", {16'd0, alu_value}, 32'd0);
    chk("rst_flags", {30'd0, alu_f1, alu_f2}, 32'd0);
    chk("rst_highlow", {31'd0, alu_highlow}, 32'd0);
    chk("rst_halted_illegal", {30'd0, halted, illegal}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, {29'd0, S_FETCH});
    reset = 1'b0;
    @(posedge clock);
    #1 chk("first_req", {31'd0, mem_req}, 32'd1);

    //        word                                  addr          dly a            b       chkb r8    f1    f2    c             f3    ach   naddr         ill   abort
    run_instr(mk(OP_MOV,  4'd2, 4'd0, 1'b0, 16'h0), 32'h0,        3, 32'd0,      32'd0,  0, 32'd0, 1'b0, 1'b0, 32'd5,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
    run_instr(mk(OP_MOV,  4'd3, 4'd2, 1'b0, 16'h0), 32'h1,        0, 32'd5,      32'd0,  0, 32'd0, 1'b0, 1'b0, 32'd7,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
    run_instr(mk(OP_ADD,  4'd1, 4'd2, 1'b0, 16'h3000), 32'h2,     3, 32'd5,      32'd7,  1, 32'd0, 1'b0, 1'b0, 32'd12,       1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
    run_instr(mk(OP_LDH,  4'd8, 4'd1, 1'b1, 16'hABCD), 32'h3,     1, 32'd12,     32'd0,  0, 32'd0, 1'b0, 1'b0, 32'd9,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
    run_instr(mk(OP_EQ,   4'd0, 4'd8, 1'b0, 16'h8000), 32'h4,     0, 32'd9,      32'd9,  1, 32'd9, 1'b0, 1'b0, 32'd0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b0);
    run_instr(mk(OP_LT,   4'd0, 4'd8, 1'b0, 16'h1000), 32'h5,     0, 32'd9,      32'd12, 1, 32'd9, 1'b1, 1'b0, 32'd0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
    run_instr(mk(OP_BR,   4'd0, 4'd0, 1'b0, 16'h0), 32'h6,        0, 32'd0,      32'd0,  0, 32'd9, 1'b0, 1'b1, 32'd0,        1'b0, 1'b1, 32'h40,       1'b0, 1'b0);
    run_instr(mk(OP_BR,   4'd0, 4'd0, 1'b0, 16'h0), 32'h40,       0, 32'd0,      32'd0,  0, 32'd9, 1'b0, 1'b1, 32'd0,        1'b0, 1'b0, 32'h99,       1'b0, 1'b0);
    run_instr(mk(7'd50,   4'd1, 4'd3, 1'b0, 16'h0), 32'h41,       0, 32'd7,      32'd0,  0, 32'd9, 1'b0, 1'b1, 32'hDEAD,     1'b1, 1'b1, 32'h77,       1'b1, 1'b0);
    run_instr(mk(OP_MOV2, 4'd5, 4'd1, 1'b0, 16'h0), 32'h42,       0, 32'd12,     32'd0,  0, 32'd9, 1'b0, 1'b1, 32'h55,       1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
    run_instr(mk(OP_BR,   4'd0, 4'd5, 1'b0, 16'h0), 32'h43,       0, 32'h55,     32'd0,  0, 32'd9, 1'b0, 1'b1, 32'd0,        1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_instr(mk(OP_ADD,  4'd6, 4'd1, 1'b0, 16'h3000), 32'hFFFFFFFF, 2, 32'd12,  32'd7,  1, 32'd9, 1'b0, 1'b1, 32'd19,       1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
    run_instr(mk(OP_MOV,  4'd4, 4'd6, 1'b0, 16'h0), 32'h0,        0, 32'd19,     32'd0,  0, 32'd9, 1'b0, 1'b1, 32'h1234,     1'b0, 1'b0, 32'h0,        1'b0, 1'b1);
    run_instr(mk(OP_MOV,  4'd9, 4'd4, 1'b0, 16'h0), 32'h0,        0, 32'd0,      32'd0,  0, 32'd0, 1'b0, 1'b0, 32'd1,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
    run_instr(mk(OP_HALT, 4'd0, 4'd9, 1'b0, 16'h0), 32'h1,        0, 32'd1,      32'd0,  0, 32'd0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0);

    // WB of HALT, then terminal state
    @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("halted", {31'd0, halted}, 32'd1);
      chk("halt_req_low", {31'd0, mem_req}, 32'd0);
      chk("halt_pc", mem_addr, 32'h1);
    end
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("addr_q_drained", exp_addr_q.size(), 32'd0);
    chk("ill_q_drained", exp_ill_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
